// File: rtl/sel_stepper_2b_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sel_stepper_2b_pkg
//  Brief    : Shared types, board defaults and sel arithmetic for the
//             push-button selector stepper.
//  Revision : 1.0 - initial release
// ============================================================================
package sel_stepper_2b_pkg;

  // Operating mode of the stepper; encoding matches the mode_auto output.
  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  // Board build values; simulation overrides these with small numbers.
  localparam int c_db_cycles_board = 1_000_000;
  localparam int c_scan_div_board  = 50_000_000;

  // 2-bit wrap-around step: up=1 increments, up=0 decrements.
  function automatic logic [1:0] sel_step(input logic [1:0] cur, input logic up);
    return up ? (cur + 2'd1) : (cur - 2'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sel_stepper_2b_if.sv
`default_nettype none
// ============================================================================
//  Module   : sel_stepper_2b_if
//  Brief    : Button inputs and selector outputs of the stepper, bundled.
//             master = button/board side, slave = stepper.
//  Revision : 1.0 - initial release
// ============================================================================
interface sel_stepper_2b_if;
  logic       btn_up;
  logic       btn_dn;
  logic       btn_mode;
  logic [1:0] sel;
  logic       sel_valid;
  logic       mode_auto;

  modport master (
    output btn_up, btn_dn, btn_mode,
    input  sel, sel_valid, mode_auto
  );

  modport slave (
    input  btn_up, btn_dn, btn_mode,
    output sel, sel_valid, mode_auto
  );
endinterface
`default_nettype wire

// File: rtl/sel_stepper_2b_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Brief    : 2-FF synchronizer, debounce counter and rising-edge press pulse
//             for one raw asynchronous button.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int                 c_cnt_w    = $clog2(DB_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_level;
  logic               r_level_d;
  logic               r_press;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt   <= '0;
      r_level <= r_sync2;
    end else begin
      r_cnt <= r_cnt + c_cnt_one;
    end
  end

  // Registered one-cycle pulse on a rising debounced level; falls are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

endmodule
`default_nettype wire

// File: rtl/sel_stepper_2b.sv
`default_nettype none
// ============================================================================
//  Module   : sel_stepper_2b
//  Brief    : Debounced up/down/mode buttons drive a 2-bit selector code,
//             stepped manually or automatically every SCAN_DIV clocks.
//  Revision : 1.0 - initial release
// ============================================================================
module sel_stepper_2b
  import sel_stepper_2b_pkg::*;
#(
  parameter int DB_CYCLES = c_db_cycles_board,
  parameter int SCAN_DIV  = c_scan_div_board
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sel_stepper_2b_if.slave        bus
);

  localparam int                 c_psc_w    = $clog2(SCAN_DIV);
  localparam logic [c_psc_w-1:0] c_psc_last = c_psc_w'(SCAN_DIV - 1);
  localparam logic [c_psc_w-1:0] c_psc_one  = c_psc_w'(1);

  // Button order in the vectors: [0]=up, [1]=dn, [2]=mode.
  logic [2:0] w_raw;
  logic [2:0] w_press;
  logic [2:0] w_unused_levels;  // debounced levels are not needed at this level

  assign w_raw = {bus.btn_mode, bus.btn_dn, bus.btn_up};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (w_raw[i]),
      .btn_level (w_unused_levels[i]),
      .btn_press (w_press[i])
    );
  end

  state_t             r_state;
  state_t             w_state_next;
  logic [c_psc_w-1:0] r_psc;
  logic [c_psc_w-1:0] w_psc_next;
  logic [1:0]         r_sel;
  logic [1:0]         w_sel_next;
  logic               r_sel_valid;
  logic               w_step;

  // Next state, prescaler and sel; a mode press always wins over stepping.
  always_comb begin
    w_state_next = r_state;
    w_psc_next   = r_psc;
    w_sel_next   = r_sel;
    w_step       = 1'b0;
    case (r_state)
      ST_MANUAL: begin
        w_psc_next = '0;
        if (w_press[2]) begin
          w_state_next = ST_AUTO;
        end else if (w_press[0] ^ w_press[1]) begin
          w_step     = 1'b1;
          w_sel_next = sel_step(r_sel, w_press[0]);
        end
      end
      ST_AUTO: begin
        if (w_press[2]) begin
          w_state_next = ST_MANUAL;
          w_psc_next   = '0;
        end else if (r_psc == c_psc_last) begin
          w_psc_next = '0;
          w_step     = 1'b1;
          w_sel_next = sel_step(r_sel, 1'b1);
        end else begin
          w_psc_next = r_psc + c_psc_one;
        end
      end
      default: begin
        w_state_next = ST_MANUAL;
        w_psc_next   = '0;
      end
    endcase
  end

  // State, prescaler and selector registers; sel_valid marks each sel change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_MANUAL;
      r_psc       <= '0;
      r_sel       <= 2'b00;
      r_sel_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_psc       <= w_psc_next;
      r_sel       <= w_sel_next;
      r_sel_valid <= w_step;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;
  assign bus.mode_auto = (r_state == ST_AUTO);

endmodule
`default_nettype wire

// File: tb/tb_sel_stepper_2b.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sel_stepper_2b
//  Brief    : Directed self-checking bench for sel_stepper_2b
//             (DB_CYCLES=4, SCAN_DIV=8, so press latency is 8 clocks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sel_stepper_2b;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sel_stepper_2b_if bus ();

  sel_stepper_2b #(
    .DB_CYCLES (4),
    .SCAN_DIV  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock; stimulus and sampling happen on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one of: 0=up, 1=dn, 2=up+dn together.
  task automatic set_btns(input int which, input logic val);
    if (which == 0 || which == 2) bus.btn_up = val;
    if (which == 1 || which == 2) bus.btn_dn = val;
  endtask

  // Press for 10 clocks, release, settle; report sel_valid pulses and timing.
  task automatic pulse_btn(input int which, output int npulse, output int first_at,
                           output logic [1:0] sel_after);
    npulse   = 0;
    first_at = -1;
    set_btns(which, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (bus.sel_valid) begin
        npulse++;
        if (first_at < 0) first_at = i;
      end
      if (i == 10) set_btns(which, 1'b0);
    end
    sel_after = bus.sel;
  endtask

  task automatic reset_dut();
    rst_n        = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_dn   = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.btn_up   = 1'b1;
    bus.btn_dn   = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", bus.sel); end
    checks++; if (bus.sel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.sel_valid); end
    checks++; if (bus.mode_auto !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b expected 0", bus.mode_auto); end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 7) begin
        checks++; if (bus.sel_valid !== 1'b0 || bus.sel !== 2'd0) begin
          errors++; $display("FAIL held_press_early: valid=%b sel=%0d expected valid=0 sel=0", bus.sel_valid, bus.sel);
        end
      end
      if (i == 8) begin
        checks++; if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd1) begin
          errors++; $display("FAIL held_press_latency: valid=%b sel=%0d expected valid=1 sel=1", bus.sel_valid, bus.sel);
        end
      end
    end
    bus.btn_up = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_manual_wrap();
    int         np, fa;
    logic [1:0] s;
    int         exp_up [4] = '{1, 2, 3, 0};
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      pulse_btn(0, np, fa, s);
      checks++; if (np !== 1 || fa !== 8) begin
        errors++; $display("FAIL up_press_%0d: pulses=%0d at=%0d expected pulses=1 at=8", k, np, fa);
      end
      checks++; if (s !== exp_up[k][1:0]) begin
        errors++; $display("FAIL up_sel_%0d: got %0d expected %0d", k, s, exp_up[k]);
      end
    end
    pulse_btn(1, np, fa, s);
    checks++; if (np !== 1 || fa !== 8) begin
      errors++; $display("FAIL dn_press: pulses=%0d at=%0d expected pulses=1 at=8", np, fa);
    end
    checks++; if (s !== 2'd3) begin errors++; $display("FAIL dn_wrap_sel: got %0d expected 3", s); end
  endtask

  task automatic test_bounce();
    int n_bounce = 0;
    int np = 0;
    int fa = -1;
    for (int i = 0; i < 10; i++) begin
      bus.btn_up = (i % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        if (bus.sel_valid) n_bounce++;
      end
    end
    bus.btn_up = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (bus.sel_valid) begin
        np++;
        if (fa < 0) fa = i;
      end
      if (i == 12) bus.btn_up = 1'b0;
    end
    checks++; if (n_bounce !== 0) begin errors++; $display("FAIL bounce_glitch: pulses=%0d expected 0", n_bounce); end
    checks++; if (np !== 1 || fa !== 8) begin
      errors++; $display("FAIL bounce_settle: pulses=%0d at=%0d expected pulses=1 at=8", np, fa);
    end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL bounce_sel: got %0d expected 0", bus.sel); end
  endtask

  task automatic test_simultaneous();
    int         np, fa;
    logic [1:0] s;
    pulse_btn(2, np, fa, s);
    checks++; if (np !== 0) begin errors++; $display("FAIL simul_valid: pulses=%0d expected 0", np); end
    checks++; if (s !== 2'd0) begin errors++; $display("FAIL simul_sel: got %0d expected 0", s); end
  endtask

  task automatic test_auto();
    int         np = 0;
    logic [1:0] exp_sel = 2'd1;
    bus.btn_mode = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 7) begin
        checks++; if (bus.mode_auto !== 1'b0) begin errors++; $display("FAIL auto_enter_early: mode=%b expected 0", bus.mode_auto); end
      end
    end
    checks++; if (bus.mode_auto !== 1'b1) begin errors++; $display("FAIL auto_enter: mode=%b expected 1", bus.mode_auto); end
    // t counts clocks since mode_auto rose; steps are due at t=8,16,24,32.
    for (int t = 1; t <= 64; t++) begin
      @(negedge clk);
      if (bus.sel_valid) begin
        np++;
        checks++; if ((t % 8) != 0 || t > 32 || bus.sel !== exp_sel) begin
          errors++; $display("FAIL auto_step: t=%0d sel=%0d expected step slot with sel=%0d", t, bus.sel, exp_sel);
        end
        exp_sel = exp_sel + 2'd1;
      end
      if (t == 33) begin
        checks++; if (bus.mode_auto !== 1'b1) begin errors++; $display("FAIL auto_exit_early: mode=%b expected 1", bus.mode_auto); end
      end
      if (t == 34) begin
        checks++; if (bus.mode_auto !== 1'b0) begin errors++; $display("FAIL auto_exit: mode=%b expected 0", bus.mode_auto); end
      end
      if (t == 2)  bus.btn_mode = 1'b0;
      if (t == 3)  bus.btn_up   = 1'b1;
      if (t == 13) bus.btn_up   = 1'b0;
      if (t == 26) bus.btn_mode = 1'b1;
      if (t == 36) bus.btn_mode = 1'b0;
    end
    checks++; if (np !== 4) begin errors++; $display("FAIL auto_count: pulses=%0d expected 4", np); end
    checks++; if (bus.sel !== 2'd0) begin errors++; $display("FAIL auto_frozen_sel: got %0d expected 0", bus.sel); end
  endtask

  task automatic test_collision();
    int np = 0;
    bus.btn_mode = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (bus.mode_auto !== 1'b1) begin errors++; $display("FAIL coll_enter: mode=%b expected 1", bus.mode_auto); end
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (bus.sel_valid) np++;
      if (t == 2) bus.btn_mode = 1'b0;
      if (t == 8) begin
        checks++; if (bus.sel_valid !== 1'b1 || bus.sel !== 2'd1) begin
          errors++; $display("FAIL coll_first_step: valid=%b sel=%0d expected valid=1 sel=1", bus.sel_valid, bus.sel);
        end
        // Mode press now lands exactly on the next terminal count.
        bus.btn_mode = 1'b1;
      end
      if (t == 15) begin
        checks++; if (bus.mode_auto !== 1'b1) begin errors++; $display("FAIL coll_mode_early: mode=%b expected 1", bus.mode_auto); end
      end
      if (t == 16) begin
        checks++; if (bus.mode_auto !== 1'b0 || bus.sel_valid !== 1'b0 || bus.sel !== 2'd1) begin
          errors++; $display("FAIL coll_edge: mode=%b valid=%b sel=%0d expected mode=0 valid=0 sel=1",
                             bus.mode_auto, bus.sel_valid, bus.sel);
        end
      end
      if (t == 18) bus.btn_mode = 1'b0;
    end
    checks++; if (np !== 1 || bus.sel !== 2'd1) begin
      errors++; $display("FAIL coll_after: pulses=%0d sel=%0d expected pulses=1 sel=1", np, bus.sel);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_manual_wrap();
    test_bounce();
    test_simultaneous();
    test_auto();
    test_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
